// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline hazard controller
package pipeline_ctrl_pkg;
    typedef logic [4:0] creg_addr_t;
    localparam int MDU_CNT_W = 6;
    typedef enum logic {IDLE, MDU} ctrl_state_t;
    typedef enum logic [2:0] {HZ_NONE, HZ_DWAIT, HZ_MDU, HZ_REDIR, HZ_LU, HZ_IWAIT} hazard_cause_t;
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stall_flush_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the pipeline and stall/flush enables back to it
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;
    creg_addr_t ra1_d;
    creg_addr_t ra2_d;
    logic use1_d;
    logic use2_d;
    creg_addr_t wa_e;
    logic memread_e;
    logic mdu_start_e;
    logic redirect_e;
    logic ireq;
    logic idata_ok;
    logic dreq;
    logic ddata_ok;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;
    modport master (
        output ra1_d, ra2_d, use1_d, use2_d, wa_e, memread_e, mdu_start_e, redirect_e,
        output ireq, idata_ok, dreq, ddata_ok,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w
    );
    modport slave (
        input  ra1_d, ra2_d, use1_d, use2_d, wa_e, memread_e, mdu_start_e, redirect_e,
        input  ireq, idata_ok, dreq, ddata_ok,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w
    );
endinterface

// File: rtl/pipeline_ctrl_mdu_timer.sv
// pipeline_ctrl_mdu_timer: IDLE/MDU FSM counting the cycles a multi-cycle op holds E
module pipeline_ctrl_mdu_timer import pipeline_ctrl_pkg::*; #(
    parameter int MDU_LAT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic hold_i,
    output logic busy_o
);
    ctrl_state_t state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    // state and countdown registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // countdown freezes while the dbus holds the whole pipe; cnt==0 marks the exit cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hold_i && state_q == IDLE && start_i) begin
            state_d = MDU;
            cnt_d   = MDU_CNT_W'(MDU_LAT - 2);
        end else if (!hold_i && state_q == MDU) begin
            state_d = (cnt_q == '0) ? IDLE : MDU;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
    end
    // exit cycle is not busy so E advances after exactly MDU_LAT cycles
    assign busy_o = start_i | (state_q == MDU && cnt_q != '0);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: prioritised stall/flush generation; optional PIPELINE_CTRL_PERF_CNT_EN adds per-cause counters
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic clk,
    input  logic reset,
    pipeline_ctrl_if.slave bus
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_dwait,
    output logic [CNT_W-1:0] perf_mdu,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_iwait,
    output logic [CNT_W-1:0] perf_redir
`endif
);
    if (MDU_LAT < 2 || MDU_LAT > 63 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_ctrl: MDU_LAT must be 2..63 and CNT_W >= 1");
    end
    logic dwait, iwait, lu, mbusy;
    logic redir_pend_q, redir_pend_d;
    logic c_dw, c_mb, c_rd, c_lu, c_iw;
    hazard_cause_t cause;
    stall_flush_t sf;
    assign dwait = bus.dreq & ~bus.ddata_ok;
    assign iwait = bus.ireq & ~bus.idata_ok;
    assign lu = bus.memread_e & (bus.wa_e != '0) &
                ((bus.use1_d & (bus.ra1_d == bus.wa_e)) | (bus.use2_d & (bus.ra2_d == bus.wa_e)));
    pipeline_ctrl_mdu_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
        .clk(clk),
        .reset(reset),
        .start_i(bus.mdu_start_e),
        .hold_i(dwait),
        .busy_o(mbusy)
    );
    assign cause = dwait ? HZ_DWAIT : mbusy ? HZ_MDU : bus.redirect_e ? HZ_REDIR :
                   lu ? HZ_LU : iwait ? HZ_IWAIT : HZ_NONE;
    assign c_dw = cause == HZ_DWAIT;
    assign c_mb = cause == HZ_MDU;
    assign c_rd = cause == HZ_REDIR;
    assign c_lu = cause == HZ_LU;
    assign c_iw = cause == HZ_IWAIT;
    // only the winning cause drives the enables; a stale fetch landing after a redirect is flushed
    always_comb begin
        sf.stall_f = ~reset & (c_dw | c_mb | c_lu | c_iw);
        sf.stall_d = ~reset & (c_dw | c_mb | c_lu);
        sf.stall_e = ~reset & (c_dw | c_mb);
        sf.stall_m = ~reset & c_dw;
        sf.flush_d = reset | c_rd | c_iw | (redir_pend_q & bus.idata_ok);
        sf.flush_e = reset | c_rd | c_lu;
        sf.flush_m = reset | c_mb;
        sf.flush_w = reset | c_dw;
    end
    assign {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
            bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w} = sf;
    assign redir_pend_d = (c_rd & iwait) | (redir_pend_q & ~bus.idata_ok);
    // remembers that the in-flight fetch belongs to the wrong path
    always_ff @(posedge clk) begin
        if (reset) redir_pend_q <= 1'b0;
        else redir_pend_q <= redir_pend_d;
    end
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q [5];
    // index k counts cycles won by cause k+1, saturating at all-ones
    always_ff @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (reset) perf_q[k] <= '0;
            else if (cause == hazard_cause_t'(3'(k + 1)) && !(&perf_q[k])) perf_q[k] <= perf_q[k] + 1'b1;
        end
    end
    assign perf_dwait = perf_q[0];
    assign perf_mdu   = perf_q[1];
    assign perf_redir = perf_q[2];
    assign perf_lu    = perf_q[3];
    assign perf_iwait = perf_q[4];
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, hand sequences and random run against a rule-level model
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;
    localparam int LAT = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    pipeline_ctrl_if bus ();
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [31:0] p_dw, p_mdu, p_lu, p_iw, p_rd;
`endif
    pipeline_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        ,
        .perf_dwait(p_dw),
        .perf_mdu(p_mdu),
        .perf_lu(p_lu),
        .perf_iwait(p_iw),
        .perf_redir(p_rd)
`endif
    );
    always #5 clk = ~clk;

    // ctl bits: {use1, use2, memread, mdu_start, redirect, ireq, idata_ok, dreq, ddata_ok}
    // exp bits: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
    typedef struct {
        string nm;
        logic [4:0] ra1, ra2, wa;
        logic [8:0] ctl;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [$];

    // reference model state: MDU occupancy counted upward, pending redirect, per-cause tallies
    bit m_mdu = 0;
    int m_done = 0;
    bit m_pend = 0;
    longint m_perf [5] = '{0, 0, 0, 0, 0};

    function automatic int model_cls();
        if (bus.dreq && !bus.ddata_ok) return 1;
        if (bus.mdu_start_e || (m_mdu && m_done < LAT - 1)) return 2;
        if (bus.redirect_e) return 3;
        if (bus.memread_e && bus.wa_e != 0 &&
            ((bus.use1_d && bus.ra1_d == bus.wa_e) || (bus.use2_d && bus.ra2_d == bus.wa_e))) return 4;
        if (bus.ireq && !bus.idata_ok) return 5;
        return 0;
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        if (reset) return 8'h0F;
        case (model_cls())
            1: o = 8'hF1;
            2: o = 8'hE2;
            3: o = 8'h0C;
            4: o = 8'hC4;
            5: o = 8'h88;
            default: o = 8'h00;
        endcase
        if (m_pend && bus.idata_ok) o[3] = 1'b1;
        return o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mdu <= 0;
            m_done <= 0;
            m_pend <= 0;
            for (int k = 0; k < 5; k++) m_perf[k] <= 0;
        end else begin
            if (model_cls() != 0) m_perf[model_cls() - 1] <= m_perf[model_cls() - 1] + 1;
            if (model_cls() == 3 && bus.ireq && !bus.idata_ok) m_pend <= 1;
            else if (m_pend && bus.idata_ok) m_pend <= 0;
            if (!(bus.dreq && !bus.ddata_ok)) begin
                if (!m_mdu && bus.mdu_start_e) begin
                    m_mdu <= 1;
                    m_done <= 1;
                end else if (m_mdu && m_done == LAT - 1) m_mdu <= 0;
                else if (m_mdu) m_done <= m_done + 1;
            end
        end
    end

    function automatic logic [7:0] got();
        return {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, g, e, $time);
        end
    endtask

    task automatic drive(input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa, input logic [8:0] c);
        bus.ra1_d = ra1;
        bus.ra2_d = ra2;
        bus.wa_e = wa;
        {bus.use1_d, bus.use2_d, bus.memread_e, bus.mdu_start_e, bus.redirect_e,
         bus.ireq, bus.idata_ok, bus.dreq, bus.ddata_ok} = c;
    endtask

    task automatic step(input string nm, input logic [8:0] c, input logic [7:0] e);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, c);
        #1 chk(nm, 32'(got()), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 9'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic add(input string nm, input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa,
                       input logic [8:0] c, input logic [7:0] e);
        vec_t v;
        v.nm = nm; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.ctl = c; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        add("lu_rs2",      5'd0, 5'd5, 5'd5, 9'b011_000_000, 8'hC4);
        add("lu_wa0",      5'd0, 5'd0, 5'd0, 9'b011_000_000, 8'h00);
        add("lu_nouse",    5'd0, 5'd5, 5'd5, 9'b001_000_000, 8'h00);
        add("lu_rs1",      5'd7, 5'd0, 5'd7, 9'b101_000_000, 8'hC4);
        add("no_load",     5'd7, 5'd0, 5'd7, 9'b100_000_000, 8'h00);
        add("dwait",       5'd0, 5'd0, 5'd0, 9'b000_000_010, 8'hF1);
        add("dbus_ok",     5'd0, 5'd0, 5'd0, 9'b000_000_011, 8'h00);
        add("iwait",       5'd0, 5'd0, 5'd0, 9'b000_001_000, 8'h88);
        add("redir",       5'd0, 5'd0, 5'd0, 9'b000_010_000, 8'h0C);
        add("lu_redir",    5'd0, 5'd5, 5'd5, 9'b011_010_000, 8'h0C);
        add("dwait_redir", 5'd0, 5'd0, 5'd0, 9'b000_010_010, 8'hF1);
        add("lu_iwait",    5'd0, 5'd5, 5'd5, 9'b011_001_000, 8'hC4);
        add("mdu_start",   5'd0, 5'd0, 5'd0, 9'b000_100_000, 8'hE2);
        add("mdu_dwait",   5'd0, 5'd0, 5'd0, 9'b000_100_010, 8'hF1);
        add("mdu_redir",   5'd0, 5'd0, 5'd0, 9'b000_110_000, 8'hE2);
        add("redir_iwait", 5'd0, 5'd0, 5'd0, 9'b000_011_000, 8'h0C);

        @(negedge clk);
        drive(5'd3, 5'd3, 5'd3, 9'b111_111_010);
        #1 chk("reset_out", 32'(got()), 32'h0F);

        foreach (tbl[i]) begin
            do_reset();
            @(negedge clk);
            drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wa, tbl[i].ctl);
            #1 chk(tbl[i].nm, 32'(got()), 32'(tbl[i].exp));
        end

        // MDU with idle dbus: 7 held cycles, released on the 8th
        do_reset();
        step("mdu_c0", 9'b000_100_000, 8'hE2);
        for (int i = 1; i < 7; i++) step("mdu_cnt", 9'd0, 8'hE2);
        step("mdu_exit", 9'd0, 8'h00);
        step("mdu_after", 9'd0, 8'h00);

        // MDU with 3 dbus wait cycles mid-count: E held for 10, released on the 11th
        do_reset();
        step("mdw_c0", 9'b000_100_000, 8'hE2);
        for (int i = 1; i < 3; i++) step("mdw_cnt", 9'd0, 8'hE2);
        for (int i = 0; i < 3; i++) step("mdw_dwait", 9'b000_000_010, 8'hF1);
        for (int i = 6; i < 10; i++) step("mdw_cnt2", 9'd0, 8'hE2);
        step("mdw_exit", 9'd0, 8'h00);

        // redirect across an outstanding fetch
        do_reset();
        step("rp_redir", 9'b000_011_000, 8'h0C);
        for (int i = 0; i < 3; i++) step("rp_iwait", 9'b000_001_000, 8'h88);
        step("rp_stale", 9'b000_001_100, 8'h08);
        step("rp_clear", 9'b000_001_100, 8'h00);

        // reset in the middle of an MDU count
        do_reset();
        step("rm_c0", 9'b000_100_000, 8'hE2);
        for (int i = 1; i < 4; i++) step("rm_cnt", 9'd0, 8'hE2);
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 9'd0);
        #1 chk("rm_reset", 32'(got()), 32'h0F);
        @(posedge clk);
        #1 reset = 1'b0;
        step("rm_idle", 9'd0, 8'h00);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        chk("rm_perf", p_dw | p_mdu | p_lu | p_iw | p_rd, 32'd0);
`endif
        step("rm_idle2", 9'd0, 8'h00);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(63) == 0);
            drive(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  {1'($urandom), 1'($urandom), 1'($urandom_range(2) == 0), 1'($urandom_range(9) == 0),
                   1'($urandom_range(5) == 0), 1'($urandom), 1'($urandom_range(2) == 0),
                   1'($urandom_range(3) == 0), 1'($urandom)});
            #1 chk("rand", 32'(got()), 32'(model_out()));
        end
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        @(negedge clk);
        chk("perf_dwait", p_dw, 32'(m_perf[0]));
        chk("perf_mdu", p_mdu, 32'(m_perf[1]));
        chk("perf_redir", p_rd, 32'(m_perf[2]));
        chk("perf_lu", p_lu, 32'(m_perf[3]));
        chk("perf_iwait", p_iw, 32'(m_perf[4]));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
